// File: rtl/phoenix_pwm_pkg.sv
// phoenix_pwm_pkg: shared PWM state encoding, default width and cycle/duty clamp helpers
package phoenix_pwm_pkg;
  typedef enum logic [1:0] {IDLE, RUN, STOPPING} pwm_state_t;
  localparam int DEFAULT_PWM_COUNTER_BITS = 32;
  // Wide working type so the clamps serve any counter width up to 64 bits.
  typedef logic [63:0] pwm_word_t;
  function automatic pwm_word_t clamp_cycle(pwm_word_t cycle, pwm_word_t min_cycle);
    return cycle < min_cycle ? min_cycle : cycle;
  endfunction
  function automatic pwm_word_t clamp_duty(pwm_word_t duty, pwm_word_t cycle);
    return duty > cycle ? cycle : duty;
  endfunction
endpackage

// File: rtl/phoenix_pwm_generator_if.sv
// phoenix_pwm_generator_if: control inputs and pin/status outputs of the PWM generator
//   master drives enable/pwm_cycle/pwm_duty; slave (the generator) drives pwm_out/period_start/busy/clamped
interface phoenix_pwm_generator_if #(parameter int W = 32);
  logic         enable;
  logic [W-1:0] pwm_cycle;
  logic [W-1:0] pwm_duty;
  logic         pwm_out;
  logic         period_start;
  logic         busy;
  logic         clamped;
  modport master (output enable, pwm_cycle, pwm_duty, input pwm_out, period_start, busy, clamped);
  modport slave  (input enable, pwm_cycle, pwm_duty, output pwm_out, period_start, busy, clamped);
endinterface

// File: rtl/phoenix_pwm_generator.sv
// phoenix_pwm_generator: double-buffered glitch-free PWM pin driver with graceful stop
//   clk, reset (async, active-high)
//   bus.enable/pwm_cycle/pwm_duty in; bus.pwm_out/period_start/busy/clamped out, all registered
module phoenix_pwm_generator
  import phoenix_pwm_pkg::*;
#(
  parameter int PWM_COUNTER_BITS   = DEFAULT_PWM_COUNTER_BITS,
  parameter bit OUTPUT_ACTIVE_HIGH = 1'b1,
  parameter int MIN_CYCLE          = 2
) (
  input logic clk,
  input logic reset,
  phoenix_pwm_generator_if.slave bus
);
  localparam int W = PWM_COUNTER_BITS;
  localparam logic [W-1:0] ONE = W'(1);
  pwm_state_t state_q, state_d;
  logic [W-1:0] counter_q, counter_d;
  logic [W-1:0] shadow_cycle_q, shadow_cycle_d;
  logic [W-1:0] shadow_duty_q, shadow_duty_d;
  logic pwm_out_q, pwm_out_d;
  logic period_start_q, period_start_d;
  logic busy_q, busy_d;
  logic clamped_q, clamped_d;
  logic [W-1:0] load_cycle, load_duty;
  logic wrap, load;
  always_comb begin
    load_cycle     = W'(clamp_cycle(pwm_word_t'(bus.pwm_cycle), pwm_word_t'(MIN_CYCLE)));
    load_duty      = W'(clamp_duty(pwm_word_t'(bus.pwm_duty), pwm_word_t'(load_cycle)));
    // IDLE behaves like a permanent period boundary: enable there starts a fresh period.
    wrap           = state_q == IDLE || counter_q == shadow_cycle_q - ONE;
    load           = wrap && bus.enable;
    state_d        = bus.enable ? RUN : (wrap ? IDLE : STOPPING);
    counter_d      = wrap ? '0 : counter_q + ONE;
    shadow_cycle_d = load ? load_cycle : shadow_cycle_q;
    shadow_duty_d  = load ? load_duty : shadow_duty_q;
    busy_d         = state_d != IDLE;
    // Derived from next-state values so the pin lines up with the counter it describes.
    pwm_out_d      = (busy_d && counter_d < shadow_duty_d) == OUTPUT_ACTIVE_HIGH;
    period_start_d = busy_d && counter_d == '0;
    clamped_d      = load && (load_cycle != bus.pwm_cycle || load_duty != bus.pwm_duty);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      counter_q      <= '0;
      shadow_cycle_q <= '0;
      shadow_duty_q  <= '0;
      pwm_out_q      <= ~OUTPUT_ACTIVE_HIGH;
      period_start_q <= 1'b0;
      busy_q         <= 1'b0;
      clamped_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      counter_q      <= counter_d;
      shadow_cycle_q <= shadow_cycle_d;
      shadow_duty_q  <= shadow_duty_d;
      pwm_out_q      <= pwm_out_d;
      period_start_q <= period_start_d;
      busy_q         <= busy_d;
      clamped_q      <= clamped_d;
    end
  end
  assign bus.pwm_out      = pwm_out_q;
  assign bus.period_start = period_start_q;
  assign bus.busy         = busy_q;
  assign bus.clamped      = clamped_q;
endmodule
